// File: rtl/assist_sequencer_pkg.sv
// assist_pkg: shared types and widths for the assist sequencer slice.
//   SCALE_W     - width of the assist scale value
//   scale_t     - assist scale value type
//   seq_state_t - sequencer FSM state encoding
package assist_pkg;

   localparam int unsigned SCALE_W = 3;

   typedef logic [SCALE_W-1:0] scale_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAMP  = 2'd1,
      TRACK = 2'd2,
      BRAKE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/assist_sequencer_sync_edge.sv
// sync_edge: N-flop synchroniser with rising-edge detect and selectable reset value.
//   clk, rst_n - clock, asynchronous active-low reset
//   i_d        - asynchronous input
//   o_sync     - synchronised level (last flop)
//   o_rise     - one-cycle pulse on a synchronised rising edge
module sync_edge #(
   parameter int unsigned N       = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise
);

   logic [N-1:0] r_ff;

   // Shift chain; r_ff[0] is the first (metastability-exposed) flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ff <= {N{RST_VAL}};
      else        r_ff <= {r_ff[N-2:0], i_d};
   end

   assign o_sync = r_ff[N-1];
   assign o_rise = r_ff[N-2] & ~r_ff[N-1];

endmodule

// File: rtl/assist_sequencer.sv
// assist_sequencer: rate-limits the rider-selected assist scale, zeroes it on
// brake and ramps it down when the rider stops pedaling.
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_scale_tgt  - target assist scale (synchronous to clk)
//   i_cadence    - raw crank-sensor pulse (asynchronous)
//   i_brake_n    - raw brake lever, active-low (asynchronous)
//   o_scale_eff  - rate-limited effective scale (registered)
//   o_assist_on  - high when o_scale_eff != 0 (registered)
//   o_pedaling   - high while the idle timer is below IDLE_TO (registered)
// Build option: define ASSIST_BRAKE_LATCH_EN to hold BRAKE after lever release
// until a cadence rising edge is seen.
module assist_sequencer
   import assist_pkg::*;
#(
   parameter int unsigned RAMP_CYC = 4096,
   parameter int unsigned IDLE_TO  = 1048576
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SCALE_W-1:0] i_scale_tgt,
   input  logic               i_cadence,
   input  logic               i_brake_n,
   output logic [SCALE_W-1:0] o_scale_eff,
   output logic               o_assist_on,
   output logic               o_pedaling
);

   localparam int unsigned        STEP_W    = $clog2(RAMP_CYC);
   localparam int unsigned        IDLE_W    = $clog2(IDLE_TO + 1);
   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(RAMP_CYC - 1);
   localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_TO);

   logic              w_cad_rise;
   logic              w_cad_lvl_unused;
   logic              w_brk_n_s;
   logic              w_brk_rise_unused;
   logic              w_brk;

   logic [IDLE_W-1:0] r_idle_tmr;
   logic [IDLE_W-1:0] w_idle_nxt;
   logic              r_pedaling;

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   scale_t            r_scale;
   scale_t            w_scale_nxt;
   scale_t            r_tgt_q;
   scale_t            w_tgt;
   logic [STEP_W-1:0] r_step_tmr;
   logic [STEP_W-1:0] w_step_nxt;
   logic              r_assist_on;

   // Input synchronisers
   sync_edge #(.N(3), .RST_VAL(1'b0)) u_cad_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (i_cadence),
      .o_sync (w_cad_lvl_unused),
      .o_rise (w_cad_rise)
   );

   sync_edge #(.N(2), .RST_VAL(1'b1)) u_brk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (i_brake_n),
      .o_sync (w_brk_n_s),
      .o_rise (w_brk_rise_unused)
   );

   assign w_brk = ~w_brk_n_s;

   // Pedaling-inactivity timer, saturating at IDLE_TO
   always_comb begin
      w_idle_nxt = r_idle_tmr;
      if (w_cad_rise)                 w_idle_nxt = '0;
      else if (r_idle_tmr < IDLE_MAX) w_idle_nxt = r_idle_tmr + IDLE_W'(1);
   end

   // o_pedaling follows the timer value being loaded, so it is never stale
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_tmr <= IDLE_MAX;
         r_pedaling <= 1'b0;
      end else begin
         r_idle_tmr <= w_idle_nxt;
         r_pedaling <= (w_idle_nxt < IDLE_MAX);
      end
   end

   assign w_tgt = r_pedaling ? i_scale_tgt : '0;

   // Sequencer next-state, step timer and effective scale
   always_comb begin
      w_state_nxt = r_state;
      w_scale_nxt = r_scale;
      w_step_nxt  = r_step_tmr;
      case (r_state)
         IDLE: begin
            if (w_brk) begin
               w_state_nxt = BRAKE;
               w_scale_nxt = '0;
            end else if (w_tgt != '0) begin
               w_state_nxt = RAMP;
               w_step_nxt  = '0;
            end
         end
         RAMP: begin
            if (w_brk) begin
               w_state_nxt = BRAKE;
               w_scale_nxt = '0;
            end else if (r_scale == w_tgt) begin
               w_state_nxt = (w_tgt == '0) ? IDLE : TRACK;
            end else if (w_tgt != r_tgt_q) begin
               // Retarget restarts the step interval; direction is re-evaluated each step
               w_step_nxt = '0;
            end else if (r_step_tmr == STEP_LAST) begin
               w_step_nxt  = '0;
               w_scale_nxt = (w_tgt > r_scale) ? r_scale + SCALE_W'(1)
                                               : r_scale - SCALE_W'(1);
            end else begin
               w_step_nxt = r_step_tmr + STEP_W'(1);
            end
         end
         TRACK: begin
            if (w_brk) begin
               w_state_nxt = BRAKE;
               w_scale_nxt = '0;
            end else if (w_tgt != r_scale) begin
               w_state_nxt = RAMP;
               w_step_nxt  = '0;
            end
         end
         BRAKE: begin
            w_scale_nxt = '0;
`ifdef ASSIST_BRAKE_LATCH_EN
            if (!w_brk && w_cad_rise) w_state_nxt = IDLE;
`else
            if (!w_brk) w_state_nxt = IDLE;
`endif
         end
         default: begin
            w_state_nxt = IDLE;
            w_scale_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_scale     <= '0;
         r_step_tmr  <= '0;
         r_tgt_q     <= '0;
         r_assist_on <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_scale     <= w_scale_nxt;
         r_step_tmr  <= w_step_nxt;
         r_tgt_q     <= w_tgt;
         r_assist_on <= (w_scale_nxt != '0);
      end
   end

   assign o_scale_eff = r_scale;
   assign o_assist_on = r_assist_on;
   assign o_pedaling  = r_pedaling;

endmodule

// File: tb/tb_assist_sequencer.sv
// tb_assist_sequencer: directed + randomized bench for assist_sequencer with a
// cycle-level behavioural model (RAMP_CYC=4, IDLE_TO=64).
module tb_assist_sequencer;

   localparam int unsigned RAMP_CYC = 4;
   localparam int unsigned IDLE_TO  = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] scale_tgt;
   logic       cadence;
   logic       brake_n;
   logic [2:0] scale_eff;
   logic       assist_on;
   logic       pedaling;

   always #5 clk = ~clk;

   assist_sequencer #(.RAMP_CYC(RAMP_CYC), .IDLE_TO(IDLE_TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_scale_tgt (scale_tgt),
      .i_cadence   (cadence),
      .i_brake_n   (brake_n),
      .o_scale_eff (scale_eff),
      .o_assist_on (assist_on),
      .o_pedaling  (pedaling)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model state: pin histories, cycles since last cadence edge,
   // effective scale, brake latch, and a countdown to the next ramp step.
   bit cq[4];
   bit bq[3];
   int m_idle;
   bit m_ped;
   int m_eff;
   bit m_braked;
   bit m_ramping;
   int m_cnt;
   int m_prev_tgt;

   int cad_period = 0;
   int cad_phase  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) cq[i] = 1'b0;
      for (int i = 0; i < 3; i++) bq[i] = 1'b1;
      m_idle     = IDLE_TO;
      m_ped      = 1'b0;
      m_eff      = 0;
      m_braked   = 1'b0;
      m_ramping  = 1'b0;
      m_cnt      = 0;
      m_prev_tgt = 0;
   endtask

   // Advance the model by one clock edge using the pin values present at that edge.
   task automatic model_edge();
      int tgt;
      bit rise;
      bit brk;
      for (int i = 3; i > 0; i--) cq[i] = cq[i-1];
      cq[0] = cadence;
      for (int i = 2; i > 0; i--) bq[i] = bq[i-1];
      bq[0] = brake_n;
      rise = cq[2] & ~cq[3];
      brk  = ~bq[2];
      tgt  = m_ped ? int'(scale_tgt) : 0;

      if (m_braked) begin
         m_eff = 0;
`ifdef ASSIST_BRAKE_LATCH_EN
         if (!brk && rise) m_braked = 1'b0;
`else
         if (!brk) m_braked = 1'b0;
`endif
      end else if (brk) begin
         m_braked  = 1'b1;
         m_eff     = 0;
         m_ramping = 1'b0;
      end else if (!m_ramping) begin
         if (tgt != m_eff) begin
            m_ramping = 1'b1;
            m_cnt     = RAMP_CYC;
         end
      end else if (tgt == m_eff) begin
         m_ramping = 1'b0;
      end else if (tgt != m_prev_tgt) begin
         m_cnt = RAMP_CYC;
      end else begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_eff += (tgt > m_eff) ? 1 : -1;
            m_cnt  = RAMP_CYC;
         end
      end
      m_prev_tgt = tgt;

      if (rise) m_idle = 0;
      else if (m_idle < IDLE_TO) m_idle++;
      m_ped = (m_idle < IDLE_TO);
   endtask

   task automatic cycle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         #1;
         check("scale_eff", scale_eff, m_eff);
         check("assist_on", assist_on, (m_eff != 0));
         check("pedaling", pedaling, m_ped);
         if (cad_period > 0) begin
            cad_phase = (cad_phase + 1) % cad_period;
            cadence   = (cad_phase < 2);
         end else begin
            cadence = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_n     = 1'b0;
      scale_tgt = 3'd7;
      cadence   = 1'b0;
      brake_n   = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_scale", scale_eff, 0);
      check("reset_assist", assist_on, 0);
      check("reset_ped", pedaling, 0);
      rst_n = 1'b1;

      // No cadence: nothing moves despite a maximal target
      cycle(200);
      check("no_cad_scale", scale_eff, 0);
      check("no_cad_ped", pedaling, 0);

      // Pedaling at target 3
      scale_tgt  = 3'd3;
      cad_period = 20;
      cycle(60);
      check("ramp_to_3", scale_eff, 3);
      check("ramp_to_3_on", assist_on, 1);

      // Up to 5, then brake from TRACK
      scale_tgt = 3'd5;
      cycle(40);
      check("ramp_to_5", scale_eff, 5);
      brake_n = 1'b0;
      cycle(3);
      check("brake_zero_3cyc", scale_eff, 0);
      check("brake_assist_off", assist_on, 0);
      cycle(10);
      brake_n = 1'b1;
      cycle(60);
      check("after_brake_5", scale_eff, 5);

      // Stop pedaling: ramps down to 0
      cad_period = 0;
      cycle(150);
      check("idle_ramp_down", scale_eff, 0);
      check("idle_ped_low", pedaling, 0);

      // Mid-ramp retarget from 2 (toward 7) down to 1
      cad_period = 20;
      scale_tgt  = 3'd7;
      found      = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         cycle(1);
         if (m_eff == 2 && m_ramping) found = 1'b1;
      end
      check("wait_eff2", found, 1);
      scale_tgt = 3'd1;
      cycle(20);
      check("retarget_no_overshoot", scale_eff, 1);

      // Brake landing on a step edge
      scale_tgt = 3'd6;
      found     = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         cycle(1);
         if (m_ramping && m_cnt == 3 && m_eff != 6) found = 1'b1;
      end
      check("wait_step_align", found, 1);
      brake_n = 1'b0;
      cycle(3);
      check("brake_on_step", scale_eff, 0);
      cycle(5);
      brake_n = 1'b1;
      cycle(40);

      // Randomized traffic with one asynchronous reset mid-run
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) scale_tgt = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) brake_n = ~brake_n;
         if ($urandom_range(0, 299) == 0)
            cad_period = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(8, 30));
         if (k == 1500) begin
            rst_n = 1'b0;
            #2;
            check("async_rst_scale", scale_eff, 0);
            check("async_rst_assist", assist_on, 0);
            check("async_rst_ped", pedaling, 0);
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         cycle(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
